mnist_patch_scheduler: RTL

- Sequences the binarised-MNIST classifier datapath.
- Crops and subsamples a 28x28 binary patch from a per-pixel binarised video stream, then issues it to the classifier with a one-cycle valid.
- Waits for the classifier's count/number result, with a timeout, and presents the latest classification to downstream overlay/register logic.
- Sits between the camera binariser and the classifier unit; one frame in flight at a time.

---
 rtl/mnist_patch_scheduler_if.sv | 31 +++
 rtl/mnist_patch_scheduler.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mnist_patch_scheduler_if.sv
// rtl/mnist_patch_scheduler_if.sv - pixel stream, classifier issue/result and result-out bundle
interface mnist_patch_scheduler_if;
   logic         s_pix_first;
   logic         s_pix_last;
   logic         s_pix_bin;
   logic         s_pix_valid;
   logic [783:0] m_mnist_data;
   logic         m_mnist_valid;
   logic [1:0]   s_res_count;
   logic [3:0]   s_res_number;
   logic         s_res_valid;
   logic [1:0]   out_count;
   logic [3:0]   out_number;
   logic         out_valid;

   // scheduler side
   modport master (
      input  s_pix_first, s_pix_last, s_pix_bin, s_pix_valid,
      output m_mnist_data, m_mnist_valid,
      input  s_res_count, s_res_number, s_res_valid,
      output out_count, out_number, out_valid
   );

   // camera / classifier / overlay side
   modport slave (
      output s_pix_first, s_pix_last, s_pix_bin, s_pix_valid,
      input  m_mnist_data, m_mnist_valid,
      output s_res_count, s_res_number, s_res_valid,
      input  out_count, out_number, out_valid
   );
endinterface

// File: rtl/mnist_patch_scheduler.sv
// rtl/mnist_patch_scheduler.sv - crops a 28x28 patch from a binarised stream, issues it and awaits the result
module mnist_patch_scheduler #(
   parameter int X_WIDTH     = 11,
   parameter int Y_WIDTH     = 10,
   parameter int TIMEOUT     = 255,
   parameter int TIMER_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_cke,
   input  logic                   i_cfg_enable,
   input  logic [X_WIDTH-1:0]     i_cfg_x_offset,
   input  logic [Y_WIDTH-1:0]     i_cfg_y_offset,
   input  logic [1:0]             i_cfg_scale,
   mnist_patch_scheduler_if.master bus,
   output logic                   o_busy,
   output logic                   o_status_timeout
);

   typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_ISSUE, S_WAIT} state_t;

   state_t                 r_state;
   logic [X_WIDTH-1:0]     r_x;
   logic [Y_WIDTH-1:0]     r_y;
   logic [X_WIDTH-1:0]     r_off_x;
   logic [Y_WIDTH-1:0]     r_off_y;
   logic [1:0]             r_scale;
   logic [783:0]           r_data;
   logic                   r_mvalid;
   logic [1:0]             r_count;
   logic [3:0]             r_number;
   logic                   r_out_valid;
   logic                   r_busy;
   logic                   r_status;
   logic [TIMER_WIDTH-1:0] r_timer;

   logic                   w_pix;
   logic                   w_start;
   logic [X_WIDTH-1:0]     w_px;
   logic [Y_WIDTH-1:0]     w_py;
   logic [X_WIDTH-1:0]     w_off_x;
   logic [Y_WIDTH-1:0]     w_off_y;
   logic [1:0]             w_scale;
   logic [X_WIDTH-1:0]     w_dx;
   logic [Y_WIDTH-1:0]     w_dy;
   logic [X_WIDTH-1:0]     w_col_full;
   logic [Y_WIDTH-1:0]     w_row_full;
   logic                   w_x_ok;
   logic                   w_y_ok;
   logic [9:0]             w_idx;
   logic [Y_WIDTH+1:0]     w_last_line;
   logic                   w_line_end;
   logic [783:0]           w_next_data;

   // A frame-start pixel sits at (0,0) regardless of the running counters;
   // on a capture start the sampling uses the live config being latched.
   assign w_pix       = bus.s_pix_valid;
   assign w_start     = w_pix & bus.s_pix_first;
   assign w_px        = bus.s_pix_first ? '0 : r_x;
   assign w_py        = bus.s_pix_first ? '0 : r_y;
   assign w_off_x     = w_start ? i_cfg_x_offset : r_off_x;
   assign w_off_y     = w_start ? i_cfg_y_offset : r_off_y;
   assign w_scale     = w_start ? i_cfg_scale    : r_scale;
   assign w_dx        = w_px - w_off_x;
   assign w_dy        = w_py - w_off_y;
   assign w_col_full  = w_dx >> w_scale;
   assign w_row_full  = w_dy >> w_scale;
   assign w_x_ok      = (w_px >= w_off_x) && ((w_dx & ~({X_WIDTH{1'b1}} << w_scale)) == '0)
                        && (w_col_full < X_WIDTH'(28));
   assign w_y_ok      = (w_py >= w_off_y) && ((w_dy & ~({Y_WIDTH{1'b1}} << w_scale)) == '0)
                        && (w_row_full < Y_WIDTH'(28));
   assign w_idx       = ({5'd0, w_row_full[4:0]} * 10'd28) + {5'd0, w_col_full[4:0]};
   assign w_last_line = {2'b00, r_off_y} + ({{(Y_WIDTH-3){1'b0}}, 5'd27} << r_scale);
   assign w_line_end  = w_pix & bus.s_pix_last & ({2'b00, w_py} == w_last_line);

   // Next patch contents: cleared on a capture start, then the current pixel if it lands on the grid
   always_comb begin
      w_next_data = w_start ? '0 : r_data;
      if (w_pix && w_x_ok && w_y_ok) begin
         w_next_data[w_idx] = bus.s_pix_bin;
      end
   end

   // Source pixel position, tracked in every state
   always_ff @(posedge clk) begin
      if (reset) begin
         r_x <= '0;
         r_y <= '0;
      end else if (i_cke && w_pix) begin
         if (bus.s_pix_last) begin
            r_x <= '0;
            r_y <= w_py + Y_WIDTH'(1);
         end else begin
            r_x <= w_px + X_WIDTH'(1);
            r_y <= w_py;
         end
      end
   end

   // Capture / issue / wait sequencer with registered strobes and status
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_off_x     <= '0;
         r_off_y     <= '0;
         r_scale     <= '0;
         r_data      <= '0;
         r_mvalid    <= 1'b0;
         r_count     <= '0;
         r_number    <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_status    <= 1'b0;
         r_timer     <= '0;
      end else if (i_cke) begin
         r_mvalid    <= 1'b0;
         r_out_valid <= 1'b0;
         if (!i_cfg_enable) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_start) begin
                     r_off_x <= i_cfg_x_offset;
                     r_off_y <= i_cfg_y_offset;
                     r_scale <= i_cfg_scale;
                     r_data  <= w_next_data;
                     r_state <= S_CAPTURE;
                     r_busy  <= 1'b1;
                  end
               end
               S_CAPTURE: begin
                  r_data <= w_next_data;
                  if (w_start) begin
                     r_off_x <= i_cfg_x_offset;
                     r_off_y <= i_cfg_y_offset;
                     r_scale <= i_cfg_scale;
                  end else if (w_line_end) begin
                     r_state  <= S_ISSUE;
                     r_mvalid <= 1'b1;
                  end
               end
               S_ISSUE: begin
                  r_timer <= '0;
                  r_state <= S_WAIT;
               end
               S_WAIT: begin
                  if (bus.s_res_valid) begin
                     r_count     <= bus.s_res_count;
                     r_number    <= bus.s_res_number;
                     r_out_valid <= 1'b1;
                     r_status    <= 1'b0;
                     r_state     <= S_IDLE;
                     r_busy      <= 1'b0;
                  end else if (r_timer == TIMER_WIDTH'(TIMEOUT)) begin
                     r_status <= 1'b1;
                     r_state  <= S_IDLE;
                     r_busy   <= 1'b0;
                  end else begin
                     r_timer <= r_timer + TIMER_WIDTH'(1);
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.m_mnist_data  = r_data;
   assign bus.m_mnist_valid = r_mvalid;
   assign bus.out_count     = r_count;
   assign bus.out_number    = r_number;
   assign bus.out_valid     = r_out_valid;
   assign o_busy            = r_busy;
   assign o_status_timeout  = r_status;

endmodule
